dut_port_arbiter: RTL and testbench

- Shares the single write port and single read port of the 8-entry x 1-bit `dut` storage block between NUM_CLIENTS requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Drives `dut` en strictly on its rdy, returns read data or a write acknowledge to the winning client, and aborts on a rdy timeout.
- Sits between client logic and the `dut` instance in the wrapper.

---
 rtl/dut_arb_pkg.sv | 19 +
 rtl/dut_port_arbiter_rr_arbiter.sv | 30 +++
 rtl/dut_port_arbiter.sv | 112 +++++++++++
 tb/tb_dut_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dut_arb_pkg.sv
// Shared widths, FSM state and op encoding for the dut port arbiter.
package dut_arb_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 1;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dut_port_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: scans from last_grant+1 upward with wrap.
module rr_arbiter
    import dut_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!any && req[idx]) begin
                any            = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/dut_port_arbiter.sv
// Round-robin sharing of the dut write/read ports between NUM_CLIENTS requesters,
// one transaction in flight, with a rdy timeout that aborts the transfer.
module dut_port_arbiter
    import dut_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] req_addr,
    input  logic [NUM_CLIENTS-1:0]        req_wdata,
    output logic [NUM_CLIENTS-1:0]        resp_valid,
    output logic                          resp_data,
    output logic                          resp_err,
    output logic [ADDR_W-1:0]             write_address,
    output logic [DATA_W-1:0]             write_data,
    output logic                          write_en,
    input  logic                          write_rdy,
    output logic [ADDR_W-1:0]             read_address,
    output logic                          read_en,
    input  logic [DATA_W-1:0]             read_data,
    input  logic                          read_rdy
);
    localparam int IW = idx_w(NUM_CLIENTS);

    state_t                   state;
    logic [IW-1:0]            last_grant;
    logic [IW-1:0]            gnt_idx;
    logic                     op;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [DATA_W-1:0]        rdata_q;
    logic                     err_q;
    logic [7:0]               cnt;

    logic [NUM_CLIENTS-1:0]   arb_gnt;
    logic [IW-1:0]            arb_idx;
    logic                     arb_any;
    logic                     issue;
    logic                     rdy;

    rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_gnt),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    assign issue = (state == ISSUE);
    assign rdy   = (op == OP_WRITE) ? write_rdy : read_rdy;

    // Enables follow rdy combinationally so the dut never sees en without rdy.
    assign write_en      = issue && (op == OP_WRITE) && write_rdy;
    assign read_en       = issue && (op == OP_READ)  && read_rdy;
    assign write_address = addr_q;
    assign read_address  = addr_q;
    assign write_data    = wdata_q;

    assign req_ready  = (state == IDLE) ? arb_gnt : '0;
    assign resp_valid = (state == RESP) ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
    assign resp_data  = (state == RESP) && rdata_q[0];
    assign resp_err   = (state == RESP) && err_q;

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_CLIENTS - 1);
            gnt_idx    <= '0;
            op         <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (arb_any) begin
                    gnt_idx <= arb_idx;
                    op      <= req_write[arb_idx];
                    addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    wdata_q <= req_wdata[arb_idx];
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    cnt     <= '0;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    // A transfer firing on the timeout cycle still completes cleanly.
                    if (rdy) begin
                        if (op == OP_READ) rdata_q <= read_data;
                        state <= RESP;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    last_grant <= gnt_idx;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dut_port_arbiter.sv
// Directed and random checks of dut_port_arbiter against a behavioural 8x1 dut store.
module tb_dut_port_arbiter;
    logic       CLK;
    logic       RST_N;
    logic [1:0] req_valid, req_ready, req_write, req_wdata, resp_valid;
    logic [5:0] req_addr;
    logic       resp_data, resp_err;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy, read_en, read_data, read_rdy;

    int n_cmp = 0;
    int n_err = 0;

    dut_port_arbiter #(.NUM_CLIENTS(2), .TIMEOUT(15)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural dut storage.
    logic [7:0] mem;
    always @(posedge CLK) begin
        if (RST_N) mem <= '0;
        else if (write_en) mem[write_address] <= write_data;
    end
    assign read_data = mem[read_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b1; req_valid = '0; write_rdy = 1'b0; read_rdy = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b0;
    endtask

    // One transaction from client c; rdy low for the first `stall` ISSUE cycles, or random.
    task automatic txn(input int c, input bit wr, input logic [2:0] a, input logic d,
                       input int stall, input bit rnd,
                       output logic rd, output logic er, output int lat, output int ec,
                       output logic [2:0] ea, output logic ed, output int aw);
        bit acc;
        int cyc;
        acc = 0; cyc = 0; lat = -1; ec = -1; aw = -1; rd = 0; er = 0; ea = '0; ed = 0;
        @(negedge CLK);
        req_valid[c] = 1'b1; req_write[c] = wr; req_addr[3*c +: 3] = a; req_wdata[c] = d;
        for (int t = 0; t < 64 && lat < 0; t++) begin
            if (acc) begin
                if (rnd) begin
                    write_rdy = 1'($urandom % 2);
                    read_rdy  = 1'($urandom % 2);
                end else begin
                    write_rdy = (cyc > stall);
                    read_rdy  = (cyc > stall);
                end
            end
            #1;
            chk("en_rdy", {31'b0, (write_en & ~write_rdy) | (read_en & ~read_rdy) | (write_en & read_en)}, 0);
            if (!acc) begin
                if (req_ready != 0) begin
                    chk("ready_who", req_ready, 32'(1) << c);
                    acc = 1; aw = t;
                end
            end else begin
                if ((write_en | read_en) && ec < 0) begin
                    ec = cyc; ea = write_en ? write_address : read_address; ed = write_data;
                end
                if (resp_valid != 0) begin
                    chk("resp_who", resp_valid, 32'(1) << c);
                    lat = cyc; rd = resp_data; er = resp_err;
                end
            end
            @(negedge CLK);
            if (acc) begin
                req_valid[c] = 1'b0;
                cyc++;
            end
        end
        if (lat < 0) chk("txn_done", 0, 1);
    endtask

    logic       rd, er, ed;
    logic [2:0] ea;
    int         lat, ec, aw;
    int         nresp0, nresp1, ngr, last_g;
    logic [7:0] ref_mem;
    int         c;
    bit         wr;
    logic [2:0] a;
    logic       d;

    initial begin
        RST_N = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        write_rdy = 1'b0; read_rdy = 1'b0;

        // Reset state
        @(negedge CLK); @(negedge CLK); #1;
        chk("reset_outs", {req_ready, resp_valid, write_en, read_en, resp_data, resp_err,
                           write_address, read_address, write_data}, 0);
        RST_N = 1'b0;

        // Basic write then read
        txn(0, 1, 3'd5, 1'b1, 0, 0, rd, er, lat, ec, ea, ed, aw);
        chk("w_accept", aw, 0); chk("w_en_cyc", ec, 1); chk("w_addr", ea, 5);
        chk("w_data", ed, 1); chk("w_lat", lat, 2); chk("w_err", er, 0); chk("w_rdata", rd, 0);
        txn(0, 0, 3'd5, 1'b0, 0, 0, rd, er, lat, ec, ea, ed, aw);
        chk("r_en_cyc", ec, 1); chk("r_addr", ea, 5); chk("r_data", rd, 1);
        chk("r_lat", lat, 2); chk("r_err", er, 0);

        // Read with rdy stalled 4 cycles
        txn(1, 1, 3'd2, 1'b0, 0, 0, rd, er, lat, ec, ea, ed, aw);
        txn(1, 0, 3'd2, 1'b0, 4, 0, rd, er, lat, ec, ea, ed, aw);
        chk("stall_en_cyc", ec, 5); chk("stall_lat", lat, 6);
        chk("stall_data", rd, 0); chk("stall_err", er, 0);

        // Write timeout, then a normal read proving nothing was written
        txn(0, 1, 3'd3, 1'b1, 1000, 0, rd, er, lat, ec, ea, ed, aw);
        chk("to_en", ec, -1); chk("to_lat", lat, 17); chk("to_err", er, 1); chk("to_data", rd, 0);
        txn(0, 0, 3'd3, 1'b0, 0, 0, rd, er, lat, ec, ea, ed, aw);
        chk("post_to_data", rd, 0); chk("post_to_err", er, 0); chk("post_to_lat", lat, 2);

        // Reset during ISSUE of a client1 read
        @(negedge CLK);
        read_rdy = 1'b0; write_rdy = 1'b0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[5:3] = 3'd4;
        #1 chk("rst_acc", req_ready, 2'b10);
        @(negedge CLK);
        req_valid = '0; RST_N = 1'b1;
        @(negedge CLK);
        read_rdy = 1'b1; write_rdy = 1'b1;
        #1 chk("rst_mid_outs", {resp_valid, write_en, read_en, resp_data, resp_err,
                                write_address, read_address, write_data}, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        req_valid = 2'b11; req_write = 2'b00;
        #1 chk("rst_no_resp", resp_valid, 0);
        chk("rst_prio", req_ready, 2'b01);
        @(negedge CLK);
        req_valid = '0;
        @(negedge CLK); @(negedge CLK);

        // Both clients requesting back to back
        do_reset();
        nresp0 = 0; nresp1 = 0; ngr = 0; last_g = 1;
        write_rdy = 1'b1; read_rdy = 1'b1; req_write = 2'b00; req_addr = {3'd1, 3'd0};
        for (int t = 0; t < 60 && (nresp0 + nresp1) < 8; t++) begin
            @(negedge CLK);
            req_valid = (ngr < 8) ? 2'b11 : 2'b00;
            #1;
            if (req_ready != 0) begin
                chk("alt_grant", req_ready, 32'(1) << (1 - last_g));
                last_g = int'(req_ready[1]); ngr++;
            end
            if (resp_valid != 0) begin
                chk("alt_resp", resp_valid, 32'(1) << last_g);
                if (resp_valid[1]) nresp1++; else nresp0++;
            end
        end
        req_valid = '0;
        chk("alt_grants", ngr, 8); chk("alt_n0", nresp0, 4); chk("alt_n1", nresp1, 4);

        // Random traffic against a reference store
        do_reset();
        ref_mem = '0;
        for (int k = 0; k < 1000; k++) begin
            c = int'($urandom_range(0, 1)); wr = 1'($urandom % 2);
            a = 3'($urandom % 8); d = 1'($urandom % 2);
            txn(c, wr, a, d, 0, 1, rd, er, lat, ec, ea, ed, aw);
            if (!er) begin
                if (wr) ref_mem[a] = d;
                else chk("rand_rd", rd, ref_mem[a]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
